// File: rtl/phi2_mode_detect.sv
// phi2_mode_detect
//   Classifies the once-per-second PHI2 frequency word as ABSENT / C64 / C128 /
//   UNKNOWN, debounces the class over CONFIRM consecutive samples and publishes
//   a stable host-mode indication. Once locked, the published mode is held
//   while a different class is being confirmed (hysteresis).
//
// Ports
//   clk_ref      in   1   reference clock (REF_HZ cycles per sample period)
//   rst_n        in   1   asynchronous active-low reset
//   freq_hz      in   32  measured PHI2 frequency in Hz, unsigned
//   mode         out  2   locked class: 00 ABSENT, 01 C64, 10 C128, 11 UNKNOWN
//   mode_valid   out  1   set once any class has locked, cleared only by reset
//   mode_change  out  1   one-cycle pulse when mode is loaded with a new value
//   clk_absent   out  1   most recent sample classified ABSENT
//   video_pal    out  1   (only with PHI2_MODE_DET_VIDEO_STD_EN) PAL/NTSC guess
//
// Optional feature macro: PHI2_MODE_DET_VIDEO_STD_EN adds the video_pal output
// and its PAL_SPLIT parameter.

module phi2_mode_detect #(
  parameter int unsigned REF_HZ     = 50000000,
  parameter int unsigned ABSENT_MAX = 100000,
  parameter int unsigned C64_MIN    = 900000,
  parameter int unsigned C64_MAX    = 1100000,
  parameter int unsigned C128_MIN   = 1800000,
  parameter int unsigned C128_MAX   = 2200000,
  parameter int unsigned CONFIRM    = 3
`ifdef PHI2_MODE_DET_VIDEO_STD_EN
  , parameter int unsigned PAL_SPLIT = 1004000
`endif
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic [31:0] freq_hz,
  output logic [1:0]  mode,
  output logic        mode_valid,
  output logic        mode_change,
  output logic        clk_absent
`ifdef PHI2_MODE_DET_VIDEO_STD_EN
  , output logic      video_pal
`endif
);

  localparam int TW = (REF_HZ > 1) ? $clog2(REF_HZ) : 1;
  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_HZ - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(CONFIRM);

  typedef enum logic [1:0] {
    CLS_ABSENT  = 2'b00,
    CLS_C64     = 2'b01,
    CLS_C128    = 2'b10,
    CLS_UNKNOWN = 2'b11
  } cls_t;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  logic [TW-1:0] timer;
  logic          tick;
  cls_t          cls;

  state_t        state_q, state_d;
  cls_t          cand_q, cand_d;
  logic [CW-1:0] count_q, count_d;
  cls_t          mode_q, mode_d;
  logic          valid_q, valid_d;
  logic          change_q, change_d;
  logic          absent_q, absent_d;
  logic [CW:0]   count_inc;
  logic          restart;
  logic          do_lock;
  cls_t          lock_cls;
`ifdef PHI2_MODE_DET_VIDEO_STD_EN
  logic          pal_q, pal_d;
  logic          pal_update;
`endif

  // Sample period timer; tick marks the last cycle of each period so the
  // first tick lands REF_HZ cycles after reset release.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign tick = (timer == TIMER_LAST);

  // Band classification; ABSENT wins over the frequency bands.
  always_comb begin
    cls = CLS_UNKNOWN;
    if (freq_hz <= 32'(ABSENT_MAX)) begin
      cls = CLS_ABSENT;
    end else if (freq_hz >= 32'(C64_MIN) && freq_hz <= 32'(C64_MAX)) begin
      cls = CLS_C64;
    end else if (freq_hz >= 32'(C128_MIN) && freq_hz <= 32'(C128_MAX)) begin
      cls = CLS_C128;
    end
  end

  assign count_inc = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};

  // Next-state logic. A "restart" begins a new candidate run of length one;
  // with CONFIRM==1 that run is already long enough, so it locks at once.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    count_d  = count_q;
    mode_d   = mode_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    absent_d = absent_q;
    restart  = 1'b0;
    do_lock  = 1'b0;
    lock_cls = cand_q;
    if (tick) begin
      absent_d = (cls == CLS_ABSENT);
      unique case (state_q)
        ST_SEARCH: restart = 1'b1;
        ST_CONFIRM: begin
          if (cls == cand_q) begin
            if (count_inc == (CW+1)'(CONFIRM)) begin
              do_lock  = 1'b1;
              lock_cls = cand_q;
              count_d  = COUNT_FULL;
            end else begin
              count_d = count_inc[CW-1:0];
            end
          end else begin
            restart = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (cls != mode_q) begin
            restart = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
      if (restart) begin
        cand_d  = cls;
        count_d = COUNT_ONE;
        if (CONFIRM == 1) begin
          do_lock  = 1'b1;
          lock_cls = cls;
        end else begin
          state_d = ST_CONFIRM;
        end
      end
      if (do_lock) begin
        mode_d   = lock_cls;
        valid_d  = 1'b1;
        change_d = !valid_q || (lock_cls != mode_q);
        state_d  = ST_LOCKED;
      end
    end
  end

`ifdef PHI2_MODE_DET_VIDEO_STD_EN
  // Video standard is re-evaluated whenever the locked class is confirmed,
  // using the sample that confirmed it.
  always_comb begin
    pal_d      = pal_q;
    pal_update = do_lock || (tick && state_q == ST_LOCKED && cls == mode_q);
    if (pal_update) begin
      unique case (mode_d)
        CLS_C64:  pal_d = (freq_hz < 32'(PAL_SPLIT));
        CLS_C128: pal_d = (freq_hz < 32'(2 * PAL_SPLIT));
        default:  pal_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      pal_q <= 1'b0;
    end else begin
      pal_q <= pal_d;
    end
  end

  assign video_pal = pal_q;
`endif

  // State and output registers.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      cand_q   <= CLS_ABSENT;
      count_q  <= '0;
      mode_q   <= CLS_ABSENT;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      absent_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      absent_q <= absent_d;
    end
  end

  assign mode        = mode_q;
  assign mode_valid  = valid_q;
  assign mode_change = change_q;
  assign clk_absent  = absent_q;

endmodule

// File: tb/tb_phi2_mode_detect.sv
// tb_phi2_mode_detect
//   Directed and randomized bench for phi2_mode_detect with REF_HZ=10 and
//   CONFIRM=3. Expected outputs come from a run-length model: the mode locks
//   to a class on the sample where its run of consecutive identical classes
//   reaches CONFIRM. Define PHI2_MODE_DET_VIDEO_STD_EN to also cover video_pal.

module tb_phi2_mode_detect;

  localparam int REF  = 10;
  localparam int CONF = 3;

  logic        clk_ref = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] freq_hz = '0;
  logic [1:0]  mode;
  logic        mode_valid;
  logic        mode_change;
  logic        clk_absent;
`ifdef PHI2_MODE_DET_VIDEO_STD_EN
  logic        video_pal;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          run;
  bit          have_prev;
  logic [1:0]  last_cls;
  logic [1:0]  m_mode;
  logic        m_valid;
  logic        m_change;
  logic        m_absent;
  logic        m_pal;

  always #5 clk_ref = ~clk_ref;

  phi2_mode_detect #(
    .REF_HZ (REF),
    .CONFIRM(CONF)
  ) dut (
    .clk_ref    (clk_ref),
    .rst_n      (rst_n),
    .freq_hz    (freq_hz),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_change(mode_change),
    .clk_absent (clk_absent)
`ifdef PHI2_MODE_DET_VIDEO_STD_EN
    , .video_pal(video_pal)
`endif
  );

  // Band classification straight from the frequency limits.
  function automatic logic [1:0] classify(input logic [31:0] f);
    if (f <= 32'd100000) return 2'b00;
    if (f >= 32'd900000 && f <= 32'd1100000) return 2'b01;
    if (f >= 32'd1800000 && f <= 32'd2200000) return 2'b10;
    return 2'b11;
  endfunction

  task automatic modelReset();
    run       = 0;
    have_prev = 1'b0;
    last_cls  = 2'b00;
    m_mode    = 2'b00;
    m_valid   = 1'b0;
    m_change  = 1'b0;
    m_absent  = 1'b0;
    m_pal     = 1'b0;
  endtask

  task automatic modelTick(input logic [31:0] f);
    logic [1:0] c;
    c = classify(f);
    run = (have_prev && c == last_cls) ? run + 1 : 1;
    have_prev = 1'b1;
    last_cls  = c;
    m_absent  = (c == 2'b00);
    m_change  = 1'b0;
    if (run == CONF) begin
      m_change = !m_valid || (c != m_mode);
      m_mode   = c;
      m_valid  = 1'b1;
    end
    if (run >= CONF) begin
      if (m_mode == 2'b01) m_pal = (f < 32'd1004000);
      else if (m_mode == 2'b10) m_pal = (f < 32'd2008000);
      else m_pal = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".mode"}, {30'd0, mode}, {30'd0, m_mode});
    checkOutput({tag, ".valid"}, {31'd0, mode_valid}, {31'd0, m_valid});
    checkOutput({tag, ".change"}, {31'd0, mode_change}, {31'd0, m_change});
    checkOutput({tag, ".absent"}, {31'd0, clk_absent}, {31'd0, m_absent});
`ifdef PHI2_MODE_DET_VIDEO_STD_EN
    checkOutput({tag, ".pal"}, {31'd0, video_pal}, {31'd0, m_pal});
`endif
  endtask

  // One sample period. Called at the falling edge right after a tick (or at
  // reset release). freq_hz carries junk between ticks and the real sample
  // only across the tick edge; the pulse must be gone one cycle after a tick.
  task automatic applyStimulus(input string tag, input logic [31:0] f, input bit junk);
    freq_hz = junk ? $urandom : f;
    @(negedge clk_ref);
    checkOutput({tag, ".pulse_end"}, {31'd0, mode_change}, 32'd0);
    checkOutput({tag, ".hold_mode"}, {30'd0, mode}, {30'd0, m_mode});
    repeat (REF - 2) @(negedge clk_ref);
    freq_hz = f;
    @(negedge clk_ref);
    modelTick(f);
    checkAll(tag);
  endtask

  task automatic holdFreq(input string tag, input logic [31:0] f, input int n, input bit junk);
    for (int i = 0; i < n; i++) applyStimulus(tag, f, junk);
  endtask

  function automatic logic [31:0] pickFreq();
    logic [31:0] edges [8];
    edges = '{32'd100000, 32'd100001, 32'd900000, 32'd899999,
              32'd1100000, 32'd1100001, 32'd1800000, 32'd2200001};
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 100000);
      1: return $urandom_range(900000, 1100000);
      2: return $urandom_range(1800000, 2200000);
      3: return $urandom;
      4: return edges[$urandom_range(0, 7)];
      default: return $urandom_range(100001, 899999);
    endcase
  endfunction

  initial begin
    logic [31:0] f;
    int          n;

    // Reset state
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_ref);
    checkAll("reset");
    rst_n = 1'b1;

    // Absent clock locks to ABSENT on the third tick
    holdFreq("absent", 32'd0, 3, 1'b0);

    // C64 lock, then held
    holdFreq("c64", 32'd985248, 4, 1'b1);

    // Short C128 excursion returns to C64 with no pulse
    holdFreq("glitch128", 32'd2000000, 2, 1'b1);
    holdFreq("back64", 32'd1022727, 3, 1'b1);

    // Real switch to C128, held a fourth tick
    holdFreq("c128", 32'd2000000, 4, 1'b1);

    // Band edges
    holdFreq("edge_c64max", 32'd1100000, 3, 1'b1);
    holdFreq("edge_unknown", 32'd1100001, 3, 1'b1);
    holdFreq("edge_absentmax", 32'd100000, 3, 1'b1);
    holdFreq("edge_c128min", 32'd1800000, 3, 1'b1);

    // Reset while confirming a new class
    holdFreq("pre_reset", 32'd985248, 2, 1'b1);
    @(negedge clk_ref);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    @(negedge clk_ref);
    rst_n = 1'b1;
    holdFreq("post_reset", 32'd985248, 3, 1'b1);

    // Video standard split
    holdFreq("pal64", 32'd1022727, 3, 1'b1);
    holdFreq("pal64b", 32'd985248, 2, 1'b1);
    holdFreq("pal128", 32'd1970496, 3, 1'b1);

    // Randomized runs of varying length
    for (int seg = 0; seg < 40; seg++) begin
      f = pickFreq();
      n = $urandom_range(1, 4);
      holdFreq("random", f, n, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
